// File: rtl/gsens_spi_ctrl.sv
// gsens_spi_ctrl: SPI mode-3 master that configures the accelerometer and streams X samples.
// Build option GSENS_INT_TRIG_EN: trigger reads from INT2 instead of the sample timer.
module gsens_spi_ctrl #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iG_INT2,
    input  logic       iG_SDO,
    output logic       oG_CS_N,
    output logic       oG_SCLK,
    output logic       oG_SDI,
    output logic [9:0] oDIG,
    output logic       oDIG_VALID,
    output logic       oBUSY
);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int EW = $clog2(2 * 24 + 2);
    localparam logic [EW-1:0] RD_LAST = EW'(2 * 24);
    localparam logic [EW-1:0] WR_LAST = EW'(2 * 16);
`ifdef GSENS_INT_TRIG_EN
    localparam logic [2:0] NCFG = 3'd4;
`else
    localparam logic [2:0] NCFG = 3'd2;
`endif

    typedef enum logic [2:0] {CFG, GAP, WAIT, READ, DONE} state_t;

    state_t          state;
    logic            active;
    logic [2:0]      cfg_idx;
    logic [DW-1:0]   div;
    logic [EW-1:0]   edge_cnt;
    logic [23:0]     sh;
    logic [15:0]     rx;
    logic            trig;
    logic [EW-1:0]   last_edge;

    function automatic logic [15:0] cfg_word(input logic [2:0] i);
        case (i)
            3'd0:    cfg_word = 16'h3100;
            3'd1:    cfg_word = 16'h2D08;
            3'd2:    cfg_word = 16'h2E80;
            default: cfg_word = 16'h2F80;
        endcase
    endfunction

    assign last_edge = (state == READ) ? RD_LAST : WR_LAST;

`ifdef GSENS_INT_TRIG_EN
    logic [1:0] int_sync;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) int_sync <= 2'b00;
        else      int_sync <= {int_sync[0], iG_INT2};
    end

    assign trig = int_sync[1];
`else
    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    logic [TW-1:0] tmr;
    logic          int2_unused;

    assign int2_unused = iG_INT2;

    // Zero means a start is due; it stays there until WAIT services it.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            tmr <= '0;
        else if (state == WAIT && tmr == '0)
            tmr <= TW'(SAMPLE_PERIOD - 1);
        else if (tmr != '0)
            tmr <= tmr - 1'b1;
    end

    assign trig = (tmr == '0);
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= CFG;
            active     <= 1'b0;
            cfg_idx    <= 3'd0;
            div        <= '0;
            edge_cnt   <= '0;
            sh         <= '0;
            rx         <= '0;
            oG_CS_N    <= 1'b1;
            oG_SCLK    <= 1'b1;
            oG_SDI     <= 1'b0;
            oDIG       <= '0;
            oDIG_VALID <= 1'b0;
            oBUSY      <= 1'b1;
        end else begin
            oDIG_VALID <= 1'b0;
            case (state)
                CFG, READ: begin
                    if (!active) begin
                        active   <= 1'b1;
                        oG_CS_N  <= 1'b0;
                        div      <= '0;
                        edge_cnt <= '0;
                        sh       <= (state == READ) ? 24'hF20000
                                                    : {cfg_word(cfg_idx), 8'h00};
                    end else if (div == DW'(CLK_DIV - 1)) begin
                        div      <= '0;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (edge_cnt == last_edge) begin
                            oG_CS_N <= 1'b1;
                            active  <= 1'b0;
                            if (state == READ) begin
                                state <= DONE;
                            end else begin
                                state   <= GAP;
                                cfg_idx <= cfg_idx + 3'd1;
                            end
                        end else if (!edge_cnt[0]) begin
                            oG_SCLK <= 1'b0;
                            oG_SDI  <= sh[23];
                            sh      <= {sh[22:0], 1'b0};
                        end else begin
                            oG_SCLK <= 1'b1;
                            rx      <= {rx[14:0], iG_SDO};
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DONE: begin
                    // rx holds X0 in the upper byte, X1 in the lower byte
                    oDIG       <= {rx[1:0], rx[15:8]};
                    oDIG_VALID <= 1'b1;
                    div        <= '0;
                    state      <= GAP;
                end
                GAP: begin
                    if (div == DW'(2 * CLK_DIV - 1)) begin
                        div <= '0;
                        if (cfg_idx == NCFG) begin
                            state <= WAIT;
                            oBUSY <= 1'b0;
                        end else begin
                            state <= CFG;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                WAIT: begin
                    if (trig) begin
                        state <= READ;
                        oBUSY <= 1'b1;
                    end
                end
                default: state <= CFG;
            endcase
        end
    end
endmodule

// File: tb/tb_gsens_spi_ctrl.sv
// Directed bench for gsens_spi_ctrl in timer mode with a small SPI slave model.
module tb_gsens_spi_ctrl;
    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iG_INT2 = 1'b0;
    logic       iG_SDO = 1'b1;
    logic       oG_CS_N, oG_SCLK, oG_SDI, oDIG_VALID, oBUSY;
    logic [9:0] oDIG;

    gsens_spi_ctrl #(.CLK_DIV(2), .SAMPLE_PERIOD(200)) dut (
        .iCLK(iCLK), .iRST(iRST), .iG_INT2(iG_INT2), .iG_SDO(iG_SDO),
        .oG_CS_N(oG_CS_N), .oG_SCLK(oG_SCLK), .oG_SDI(oG_SDI),
        .oDIG(oDIG), .oDIG_VALID(oDIG_VALID), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    logic [23:0] tx = 24'h0034FE;
    logic [23:0] mosi = '0;
    int bitn = 0, busy_lo = 0, busy_bad = 0, sdi_bad = 0;
    int vld_cnt = 0, rd_done = 0, last_rise = 0, vld_lat = -1;
    logic cs_p = 1'b1, sclk_p = 1'b1, sdi_p = 1'b0;
    logic [23:0] words[$];
    int lens[$];
    int falls[$];
    int rises[$];
    logic [9:0] digs[$];

    // Slave and monitors, all sampled on the falling iCLK edge
    always @(negedge iCLK) begin
        if (cs_p && !oG_CS_N) begin
            bitn = 0;
            mosi = '0;
            falls.push_back(cyc);
        end
        if (!oG_CS_N && sclk_p && !oG_SCLK && bitn < 24) iG_SDO = tx[23 - bitn];
        if (!oG_CS_N && !sclk_p && oG_SCLK) begin
            mosi = {mosi[22:0], oG_SDI};
            bitn++;
        end
        if (!oG_CS_N && oG_SCLK && oG_SDI !== sdi_p) sdi_bad++;
        if (!cs_p && oG_CS_N) begin
            words.push_back(mosi);
            lens.push_back(bitn);
            rises.push_back(cyc);
            last_rise = cyc;
            if (bitn == 24) rd_done++;
        end
        if (oDIG_VALID) begin
            vld_cnt++;
            vld_lat = cyc - last_rise;
            digs.push_back(oDIG);
        end
        if (!iRST && !oBUSY) begin
            busy_lo++;
            if (!oG_CS_N) busy_bad++;
        end
        cs_p = oG_CS_N;
        sclk_p = oG_SCLK;
        sdi_p = oG_SDI;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words.size() < n && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        @(negedge iCLK);
        chk("wait_words", {31'd0, words.size() >= n}, 32'd1);
    endtask

    task automatic wait_vld(input int n, input int budget);
        int k = 0;
        while (vld_cnt < n && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        chk("wait_valid", {31'd0, vld_cnt >= n}, 32'd1);
    endtask

    initial begin
        int rel;
        int n;
        int k;
        repeat (3) @(negedge iCLK);
        chk("rst_cs_n", {31'd0, oG_CS_N}, 32'd1);
        chk("rst_sclk", {31'd0, oG_SCLK}, 32'd1);
        chk("rst_sdi", {31'd0, oG_SDI}, 32'd0);
        chk("rst_dig", {22'd0, oDIG}, 32'd0);
        chk("rst_valid", {31'd0, oDIG_VALID}, 32'd0);
        chk("rst_busy", {31'd0, oBUSY}, 32'd1);

        rel = cyc;
        iRST = 1'b0;
        repeat (4) @(negedge iCLK);
        chk("first_fall_le2", {31'd0, falls.size() > 0 && (falls[0] - rel) <= 2}, 32'd1);

        wait_words(3, 2000);
        if (words.size() >= 3) begin
            chk("cfg0_word", {8'd0, words[0]}, 32'h003100);
            chk("cfg0_len", lens[0], 32'd16);
            chk("cfg1_word", {8'd0, words[1]}, 32'h002D08);
            chk("cfg1_len", lens[1], 32'd16);
            chk("read_word", {8'd0, words[2]}, 32'hF20000);
            chk("read_len", lens[2], 32'd24);
            chk("gap0_ge4", {31'd0, (falls[1] - rises[0]) >= 4}, 32'd1);
            chk("gap1_ge4", {31'd0, (falls[2] - rises[1]) >= 4}, 32'd1);
        end

        wait_vld(1, 600);
        chk("dig_234", {22'd0, digs.size() > 0 ? digs[0] : 10'h3FF}, 32'h234);
        chk("valid_latency", vld_lat, 32'd1);
        repeat (50) @(negedge iCLK);
        chk("dig_hold", {22'd0, oDIG}, 32'h234);
        chk("valid_low", {31'd0, oDIG_VALID}, 32'd0);
        chk("busy_idle", {31'd0, oBUSY}, 32'd0);

        tx = 24'h00FF01;
        wait_vld(2, 600);
        chk("dig_1ff", {22'd0, digs.size() > 1 ? digs[1] : 10'h3FF}, 32'h1FF);

        tx = 24'h00AA55;
        wait_vld(3, 600);
        chk("dig_1aa", {22'd0, digs.size() > 2 ? digs[2] : 10'h3FF}, 32'h1AA);

        wait_vld(6, 1500);
        repeat (2) @(negedge iCLK);
        for (int i = 2; i < 7; i++) begin
            if (falls.size() > i + 1)
                chk($sformatf("period_%0d", i), falls[i + 1] - falls[i], 32'd200);
            else
                chk($sformatf("period_missing_%0d", i), 32'd0, 32'd1);
        end
        chk("valid_count", vld_cnt, 32'd6);
        chk("read_count", rd_done, 32'd6);
        chk("busy_low_seen", {31'd0, busy_lo > 0}, 32'd1);
        chk("busy_low_cs", busy_bad, 32'd0);
        chk("mosi_stable", sdi_bad, 32'd0);

        k = 0;
        while (!(!oG_CS_N && bitn == 10) && k < 400) begin
            @(negedge iCLK);
            k++;
        end
        chk("reach_bit10", {31'd0, k < 400}, 32'd1);
        iRST = 1'b1;
        #1;
        chk("abort_cs_n", {31'd0, oG_CS_N}, 32'd1);
        chk("abort_sclk", {31'd0, oG_SCLK}, 32'd1);
        chk("abort_dig", {22'd0, oDIG}, 32'd0);
        chk("abort_busy", {31'd0, oBUSY}, 32'd1);
        repeat (2) @(negedge iCLK);
        n = words.size();
        chk("partial_len", {31'd0, n > 0 && lens[n - 1] < 24}, 32'd1);
        iRST = 1'b0;
        wait_words(n + 2, 2000);
        if (words.size() >= n + 2) begin
            chk("restart_cfg0", {8'd0, words[n]}, 32'h003100);
            chk("restart_cfg1", {8'd0, words[n + 1]}, 32'h002D08);
        end
        chk("no_partial_valid", vld_cnt, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gsens_spi_ctrl.md
GSENS_SPI_CTRL -- requirements
Module: gsens_spi_ctrl

Interface
REQ-001 The block SHALL provide parameter CLK_DIV, default 25, meaning iCLK cycles per SCLK half-period (1 MHz SCLK at 50 MHz).
REQ-002 The block SHALL provide parameter SAMPLE_PERIOD, default 50000, meaning iCLK cycles between read starts in timer mode.
REQ-003 The block SHALL have port iCLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iRST, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port iG_INT2, input, 1, accelerometer INT2 pin, asynchronous to iCLK.
REQ-006 The block SHALL have port iG_SDO, input, 1, SPI MISO from the accelerometer.
REQ-007 The block SHALL have port oG_CS_N, output, 1, SPI chip select, active low.
REQ-008 The block SHALL have port oG_SCLK, output, 1, SPI clock, mode 3, idle high.
REQ-009 The block SHALL have port oG_SDI, output, 1, SPI MOSI.
REQ-010 The block SHALL have port oDIG, output, 10, the last X-axis sample in two's complement; it feeds the tilt parser's iDIG.
REQ-011 The block SHALL have port oDIG_VALID, output, 1, a one-cycle pulse marking a new oDIG.
REQ-012 The block SHALL have port oBUSY, output, 1, high while configuring or while a transaction is in flight.

Function
REQ-013 SPI framing SHALL be as follows.
- oG_CS_N falls, then one half-period elapses before the first SCLK fall.
- MOSI changes on the SCLK fall; MISO is sampled on the SCLK rise.
- Bits are sent MSB first.
- After the last rise, one half-period elapses before oG_CS_N rises.
- oG_CS_N stays high for at least 2 half-periods between transactions.
REQ-014 A write SHALL be 16 bits: {R/W=0, MB=0, addr[5:0], data[7:0]}.
REQ-015 A sample read SHALL be 24 bits.
- Command byte is 0xF2 (R=1, MB=1, addr 0x32).
- The next two MISO bytes are captured as X0, then X1.
REQ-016 The FSM SHALL have states CFG, GAP, WAIT, READ and DONE.
- From reset, CFG issues writes in order: 0x31<-0x00 (±2 g, 10-bit), then 0x2D<-0x08 (measure).
- Each transaction is followed by GAP.
- After the last configuration write, the FSM enters WAIT.
REQ-017 WAIT SHALL go to READ when the sample trigger fires (timer or interrupt, per the Configuration section).
REQ-018 READ SHALL go to DONE, DONE SHALL last exactly one cycle, and DONE SHALL then go to GAP, then WAIT.
REQ-019 In DONE, oDIG SHALL load {X1[1:0], X0[7:0]} and oDIG_VALID SHALL be 1.
- Latency from the oG_CS_N rise to oDIG_VALID is 1 iCLK cycle.
- oDIG holds its value between updates.
REQ-020 The sample timer SHALL reload at READ entry, so read starts are exactly SAMPLE_PERIOD cycles apart.
- A trigger arriving during READ, DONE or GAP is held pending and serviced on WAIT entry.
- Triggers are never overlapped and never queued beyond one.
REQ-021 oBUSY SHALL be 0 only in WAIT.
REQ-022 SCLK and bit counters SHALL be sized from CLK_DIV and 24 bits; no counter may wrap inside a transaction.

Reset
REQ-023 While iRST is high, the outputs SHALL be forced asynchronously to:
- oG_CS_N=1, oG_SCLK=1, oG_SDI=0
- oDIG=0, oDIG_VALID=0, oBUSY=1
REQ-024 Reset asserted mid-transaction SHALL abort the transaction immediately (CS_N high within the reset), discard partial data, and restart from CFG after release.
REQ-025 After reset release, the first oG_CS_N fall SHALL occur within 2 iCLK cycles.

Configuration
REQ-026 Macro GSENS_INT_TRIG_EN SHALL select the trigger source as follows.
- Defined: CFG appends writes 0x2E<-0x80 (DATA_READY enable) and 0x2F<-0x80 (map to INT2).
- Defined: iG_INT2 passes through a 2-flop synchronizer, and a synchronized high level in WAIT triggers READ.
- Defined: the SAMPLE_PERIOD timer is not built.
- Not defined: only the SAMPLE_PERIOD timer triggers, iG_INT2 is ignored, and CFG issues two writes.

Verification
REQ-027 Config check: release reset with CLK_DIV=2 and a SPI slave model → MOSI shows 0x3100 then 0x2D08 (plus 0x2E80, 0x2F80 with the macro); CS_N gaps ≥ 4 cycles.
REQ-028 Sample decode: slave returns X0=0x34, X1=0xFE → oDIG=10'h234 with a single oDIG_VALID pulse 1 cycle after CS_N rises; X0=0xFF, X1=0x01 → oDIG=10'h1FF.
REQ-029 Periodicity (timer mode): SAMPLE_PERIOD=200 → successive read CS_N falls exactly 200 cycles apart over 5 samples; oBUSY=0 only between reads.
REQ-030 Interrupt mode (macro defined): hold iG_INT2 low → no reads after CFG; pulse iG_INT2 high → READ starts within 4 cycles; hold it high → back-to-back reads separated only by GAP.
REQ-031 Reset mid-read: assert iRST at bit 10 of a read → CS_N=1, SCLK=1 in the same cycle, oDIG unchanged from 0, and CFG restarts after release.
REQ-032 SPI timing: check MOSI stable across every SCLK rise, and check the sampling edge by returning a 0xAA/0x55 alternating MISO pattern → oDIG=10'h1AA for X0=0xAA, X1=0x55.
